// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer sitting between the program counter and
// instruction memory. Issues one read at a time, holds the returned word
// for decode, and pulses the PC increment once per consumed instruction.
module instr_fetch #(
   parameter int WAIT_LIMIT = 64
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   input  logic [31:0] pc_val,
   input  logic        flush,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   input  logic        mem_busy,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        pc_inc,
   output logic        misaligned,
   output logic        timeout
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ   = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;

   // Counter wide enough to hold WAIT_LIMIT-1 even when WAIT_LIMIT is 1.
   localparam int         CW      = $clog2(WAIT_LIMIT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

   logic [2:0]    state;
   logic [CW-1:0] wait_cnt;

   // mem_addr doubles as the latched request address; it only changes
   // when IDLE accepts a new PC, so it is constant across REQ/WAIT/HOLD.
   assign mem_read    = (state == REQ);
   assign instr_valid = (state == HOLD);

   // Main sequencer: one outstanding request, sticky fault flags, and a
   // one-cycle pc_inc pulse that also serves as the guard keeping IDLE
   // from sampling pc_val before the PC has applied the increment.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         mem_addr   <= '0;
         instr      <= '0;
         instr_pc   <= '0;
         pc_inc     <= 1'b0;
         misaligned <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         pc_inc <= 1'b0;
         case (state)
            IDLE: begin
               if (en && !flush && !pc_inc && !misaligned) begin
                  if (pc_val[1:0] != 2'b00) begin
                     misaligned <= 1'b1;
                  end else begin
                     mem_addr <= pc_val;
                     state    <= REQ;
                  end
               end
            end
            REQ: begin
               if (!mem_busy) begin
                  wait_cnt <= '0;
                  state    <= flush ? DRAIN : WAIT;
               end else if (flush) begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  if (!flush) begin
                     instr    <= mem_rdata;
                     instr_pc <= mem_addr;
                     state    <= HOLD;
                  end else begin
                     state <= IDLE;
                  end
               end else if (wait_cnt == CNT_LAST) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
                  if (flush) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (mem_rvalid) begin
                  state <= IDLE;
               end else if (wait_cnt == CNT_LAST) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            HOLD: begin
               if (flush) begin
                  state <= IDLE;
               end else if (instr_ready) begin
                  pc_inc <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small memory responder and PC model
// advance with each clock, and every check goes through checkOutput.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        en = 1'b0;
   logic        en2 = 1'b0;
   logic [31:0] pcVal = '0;
   logic        flush = 1'b0;
   logic        memBusy = 1'b0;
   logic        memRvalid = 1'b0;
   logic [31:0] memRdata = '0;
   logic        instrReady = 1'b0;

   logic        memRead, instrValid, pcInc, misaligned, timeout;
   logic [31:0] memAddr, instr, instrPc;
   logic        memRead2, instrValid2, pcInc2, misaligned2, timeout2;
   logic [31:0] memAddr2, instr2, instrPc2;

   int total = 0;
   int bad = 0;

   int  autoMem = 1;
   int  autoPc = 1;
   int  respDelay = 1;
   int  pendCnt = 0;
   logic [31:0] pendAddr = '0;
   int  outstanding = 0;
   int  maxOut = 0;
   int  readCount = 0;
   int  validCount = 0;
   int  incCount = 0;
   logic [31:0] addrLog [3];
   int  nAddr = 0;

   instr_fetch dut (
      .clk(clk), .clr(clr), .en(en), .pc_val(pcVal), .flush(flush),
      .mem_read(memRead), .mem_addr(memAddr), .mem_busy(memBusy),
      .mem_rvalid(memRvalid), .mem_rdata(memRdata), .instr(instr),
      .instr_pc(instrPc), .instr_valid(instrValid), .instr_ready(instrReady),
      .pc_inc(pcInc), .misaligned(misaligned), .timeout(timeout)
   );

   instr_fetch #(.WAIT_LIMIT(4)) dut2 (
      .clk(clk), .clr(clr), .en(en2), .pc_val(pcVal), .flush(flush),
      .mem_read(memRead2), .mem_addr(memAddr2), .mem_busy(memBusy),
      .mem_rvalid(memRvalid), .mem_rdata(memRdata), .instr(instr2),
      .instr_pc(instrPc2), .instr_valid(instrValid2), .instr_ready(instrReady),
      .pc_inc(pcInc2), .misaligned(misaligned2), .timeout(timeout2)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'h0050_0093 + (addr << 8);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one clock; memory responder and PC model react to what the
   // DUT presented before the edge, outputs are settled on return.
   task automatic applyStimulus();
      logic acc, incNow, rvNow;
      logic [31:0] accAddr;
      acc     = memRead && !memBusy;
      accAddr = memAddr;
      incNow  = pcInc;
      rvNow   = memRvalid;
      @(posedge clk);
      #1;
      if (autoPc != 0 && incNow) pcVal = pcVal + 32'd4;
      if (rvNow) begin
         memRvalid = 1'b0;
         if (outstanding > 0) outstanding--;
      end
      if (acc) begin
         outstanding++;
         if (outstanding > maxOut) maxOut = outstanding;
         if (autoMem != 0) begin
            pendCnt  = respDelay;
            pendAddr = accAddr;
         end
      end
      if (pendCnt > 0) begin
         pendCnt--;
         if (pendCnt == 0) begin
            memRvalid = 1'b1;
            memRdata  = memWord(pendAddr);
         end
      end
      if (memRead) readCount++;
      if (instrValid) validCount++;
      if (pcInc) incCount++;
   endtask

   task automatic resetDut();
      clr = 1'b0;
      en = 1'b0;
      en2 = 1'b0;
      flush = 1'b0;
      memBusy = 1'b0;
      memRvalid = 1'b0;
      pendCnt = 0;
      applyStimulus();
      applyStimulus();
      outstanding = 0;
      maxOut = 0;
      readCount = 0;
      validCount = 0;
      incCount = 0;
   endtask

   initial begin
      // Test 1: reset values, then a single minimum-latency fetch.
      resetDut();
      checkOutput("rst mem_read", {31'b0, memRead}, 32'd0);
      checkOutput("rst mem_addr", memAddr, 32'd0);
      checkOutput("rst instr", instr, 32'd0);
      checkOutput("rst instr_pc", instrPc, 32'd0);
      checkOutput("rst instr_valid", {31'b0, instrValid}, 32'd0);
      checkOutput("rst pc_inc", {31'b0, pcInc}, 32'd0);
      checkOutput("rst misaligned", {31'b0, misaligned}, 32'd0);
      checkOutput("rst timeout", {31'b0, timeout}, 32'd0);
      clr = 1'b1; en = 1'b1; pcVal = 32'h0; instrReady = 1'b1;
      autoMem = 1; autoPc = 1; respDelay = 1;
      applyStimulus();
      checkOutput("t1 req mem_read", {31'b0, memRead}, 32'd1);
      checkOutput("t1 req mem_addr", memAddr, 32'h0);
      applyStimulus();
      checkOutput("t1 wait mem_read", {31'b0, memRead}, 32'd0);
      checkOutput("t1 wait valid", {31'b0, instrValid}, 32'd0);
      applyStimulus();
      checkOutput("t1 hold valid", {31'b0, instrValid}, 32'd1);
      checkOutput("t1 instr", instr, 32'h0050_0093);
      checkOutput("t1 instr_pc", instrPc, 32'h0);
      en = 1'b0;
      applyStimulus();
      checkOutput("t1 pc_inc high", {31'b0, pcInc}, 32'd1);
      checkOutput("t1 valid drop", {31'b0, instrValid}, 32'd0);
      applyStimulus();
      checkOutput("t1 pc_inc low", {31'b0, pcInc}, 32'd0);
      applyStimulus();
      checkOutput("t1 read count", readCount, 32'd1);
      checkOutput("t1 valid count", validCount, 32'd1);
      checkOutput("t1 inc count", incCount, 32'd1);

      // Test 2: three back-to-back fetches driven by the PC model.
      resetDut();
      clr = 1'b1; pcVal = 32'h0; en = 1'b1; instrReady = 1'b1; nAddr = 0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus();
         if (memRead && nAddr < 3) begin
            addrLog[nAddr] = memAddr;
            nAddr++;
         end
         if (incCount >= 3) en = 1'b0;
      end
      checkOutput("t2 req count", nAddr, 32'd3);
      checkOutput("t2 addr0", addrLog[0], 32'h0);
      checkOutput("t2 addr1", addrLog[1], 32'h4);
      checkOutput("t2 addr2", addrLog[2], 32'h8);
      checkOutput("t2 read cycles", readCount, 32'd3);
      checkOutput("t2 inc count", incCount, 32'd3);
      checkOutput("t2 max outstanding", maxOut, 32'd1);
      checkOutput("t2 final pc", pcVal, 32'hC);

      // Test 3: memory busy for three cycles while requesting.
      resetDut();
      clr = 1'b1; pcVal = 32'h14; en = 1'b1; memBusy = 1'b1; instrReady = 1'b1;
      applyStimulus();
      en = 1'b0;
      checkOutput("t3 req mem_read", {31'b0, memRead}, 32'd1);
      checkOutput("t3 req mem_addr", memAddr, 32'h14);
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("t3 busy mem_read", {31'b0, memRead}, 32'd1);
         checkOutput("t3 busy mem_addr", memAddr, 32'h14);
      end
      memBusy = 1'b0;
      applyStimulus();
      checkOutput("t3 wait mem_read", {31'b0, memRead}, 32'd0);
      applyStimulus();
      checkOutput("t3 hold valid", {31'b0, instrValid}, 32'd1);
      checkOutput("t3 instr", instr, 32'h0050_1493);
      checkOutput("t3 instr_pc", instrPc, 32'h14);
      applyStimulus();
      checkOutput("t3 pc_inc", {31'b0, pcInc}, 32'd1);
      applyStimulus();

      // Test 4: flush in WAIT, response two cycles later is dropped.
      resetDut();
      clr = 1'b1; pcVal = 32'h18; en = 1'b1; instrReady = 1'b1; respDelay = 3;
      applyStimulus();
      en = 1'b0;
      applyStimulus();
      flush = 1'b1; pcVal = 32'h20;
      applyStimulus();
      flush = 1'b0;
      checkOutput("t4 drain mem_read", {31'b0, memRead}, 32'd0);
      checkOutput("t4 drain valid", {31'b0, instrValid}, 32'd0);
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("t4 valid count", validCount, 32'd0);
      checkOutput("t4 inc count", incCount, 32'd0);
      checkOutput("t4 instr untouched", instr, 32'h0);
      respDelay = 1; en = 1'b1;
      applyStimulus();
      checkOutput("t4 refetch mem_read", {31'b0, memRead}, 32'd1);
      checkOutput("t4 refetch addr", memAddr, 32'h20);
      en = 1'b0; instrReady = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("t4 hold valid", {31'b0, instrValid}, 32'd1);
      checkOutput("t4 instr_pc", instrPc, 32'h20);
      checkOutput("t4 instr", instr, 32'h0050_2093);

      // Test 5: decode stalls, then flush beats a simultaneous ready.
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("t5 stall valid", {31'b0, instrValid}, 32'd1);
         checkOutput("t5 stall instr", instr, 32'h0050_2093);
         checkOutput("t5 stall instr_pc", instrPc, 32'h20);
         checkOutput("t5 stall pc_inc", {31'b0, pcInc}, 32'd0);
      end
      instrReady = 1'b1; flush = 1'b1;
      applyStimulus();
      flush = 1'b0;
      checkOutput("t5 flush valid", {31'b0, instrValid}, 32'd0);
      checkOutput("t5 flush pc_inc", {31'b0, pcInc}, 32'd0);
      applyStimulus();
      checkOutput("t5 inc count", incCount, 32'd0);

      // Test 6: misaligned PC, WAIT timeout on the short-limit copy,
      // then reset clears both sticky flags.
      resetDut();
      clr = 1'b1; pcVal = 32'h22; en = 1'b1;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("t6 misaligned", {31'b0, misaligned}, 32'd1);
      checkOutput("t6 mis mem_read", {31'b0, memRead}, 32'd0);
      checkOutput("t6 mis read count", readCount, 32'd0);
      pcVal = 32'h30; en2 = 1'b1;
      applyStimulus();
      en2 = 1'b0;
      checkOutput("t6 to mem_read", {31'b0, memRead2}, 32'd1);
      checkOutput("t6 to mem_addr", memAddr2, 32'h30);
      for (int i = 0; i < 4; i++) applyStimulus();
      checkOutput("t6 timeout early", {31'b0, timeout2}, 32'd0);
      applyStimulus();
      checkOutput("t6 timeout set", {31'b0, timeout2}, 32'd1);
      checkOutput("t6 to idle", {31'b0, memRead2}, 32'd0);
      checkOutput("t6 to no valid", {31'b0, instrValid2}, 32'd0);
      clr = 1'b0;
      applyStimulus();
      checkOutput("t6 clr misaligned", {31'b0, misaligned}, 32'd0);
      checkOutput("t6 clr timeout", {31'b0, timeout2}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
